// File: rtl/transceiver64.sv
// 64-bit word UART transceiver: each word travels as 8 byte frames and is acknowledged by the far end.
// Optional even parity bit per frame when TRANSCEIVER64_PARITY_EN is defined.
module transceiver64 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_wr,
  input  logic [63:0] tx_data,
  output logic        UART_TX,
  input  logic        UART_RX,
  output logic        RECEIVED_TX,
  input  logic        RECEIVED_RX,
  output logic [63:0] rx_data,
  output logic        rx_done,
  output logic        tx_done
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_WAIT_ACK
`ifdef TRANSCEIVER64_PARITY_EN
    , TX_PARITY
`endif
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
`ifdef TRANSCEIVER64_PARITY_EN
    , RX_PARITY
`endif
  } rx_state_t;

  logic        rx_meta_q, rx_sync_q, ack_meta_q, ack_sync_q;

  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [2:0]  tx_byte_q, tx_byte_d;
  logic [63:0] tx_word_q, tx_word_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_cnt_end_s;
  logic [7:0]  tx_cur_byte_s;

  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [2:0]  rx_byte_q, rx_byte_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [63:0] rx_word_q, rx_word_d;
  logic [63:0] rx_data_q, rx_data_d;
  logic        rx_done_q, rx_done_d;
  logic        ack_q, ack_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic        rx_stop_ok_s;
`ifdef TRANSCEIVER64_PARITY_EN
  logic        rx_par_err_q, rx_par_err_d;
`endif

  // Asynchronous inputs: line path resets to idle-high, ack path to deasserted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      rx_meta_q  <= UART_RX;
      rx_sync_q  <= rx_meta_q;
      ack_meta_q <= RECEIVED_RX;
      ack_sync_q <= ack_meta_q;
    end
  end

  assign tx_cnt_end_s = (tx_cnt_q == BIT_LAST);

  // Transmitter next state; the line level is derived from the next state so UART_TX is registered.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_bit_d      = tx_bit_q;
    tx_byte_d     = tx_byte_q;
    tx_word_d     = tx_word_q;
    tx_done_d     = 1'b0;
    tx_line_d     = 1'b1;
    tx_cur_byte_s = 8'd0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_state_d = TX_START;
          tx_word_d  = tx_data;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_byte_d  = 3'd0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_end_s) begin
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_end_s) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 3'd7) begin
`ifdef TRANSCEIVER64_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
`ifdef TRANSCEIVER64_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_end_s) begin
          tx_cnt_d   = 16'd0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_end_s) begin
          tx_cnt_d = 16'd0;
          if (tx_byte_q == 3'd7) begin
            tx_state_d = TX_WAIT_ACK;
          end else begin
            tx_byte_d  = tx_byte_q + 3'd1;
            tx_word_d  = {8'd0, tx_word_q[63:8]};
            tx_state_d = TX_START;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_WAIT_ACK: begin
        if (ack_sync_q) begin
          tx_done_d  = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_state_d = TX_WAIT_ACK;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    tx_cur_byte_s = tx_word_d[7:0];
    case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_cur_byte_s[tx_bit_d];
`ifdef TRANSCEIVER64_PARITY_EN
      TX_PARITY: tx_line_d = ^tx_cur_byte_s;
`endif
      default:   tx_line_d = 1'b1;
    endcase
  end

  // Transmitter state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_byte_q  <= 3'd0;
      tx_word_q  <= 64'd0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_word_q  <= tx_word_d;
      tx_line_q  <= tx_line_d;
      tx_done_q  <= tx_done_d;
    end
  end

`ifdef TRANSCEIVER64_PARITY_EN
  assign rx_stop_ok_s = rx_sync_q & ~rx_par_err_q;
`else
  assign rx_stop_ok_s = rx_sync_q;
`endif

  // Receiver next state plus the ack pulse timer; bits are sampled at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_byte_d  = rx_byte_q;
    rx_shift_d = rx_shift_q;
    rx_word_d  = rx_word_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    ack_d      = ack_q;
    ack_cnt_d  = ack_cnt_q;
`ifdef TRANSCEIVER64_PARITY_EN
    rx_par_err_d = rx_par_err_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = 16'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = 16'd0;
          rx_bit_d = 3'd0;
          // A start bit that is high at mid-bit was a glitch.
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef TRANSCEIVER64_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
`ifdef TRANSCEIVER64_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d     = 16'd0;
          rx_par_err_d = rx_sync_q ^ (^rx_shift_q);
          rx_state_d   = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = RX_IDLE;
          if (rx_stop_ok_s) begin
            rx_word_d = {rx_shift_q, rx_word_q[63:8]};
            if (rx_byte_q == 3'd7) begin
              rx_byte_d = 3'd0;
              rx_data_d = {rx_shift_q, rx_word_q[63:8]};
              rx_done_d = 1'b1;
            end else begin
              rx_byte_d = rx_byte_q + 3'd1;
            end
          end else begin
            rx_byte_d = 3'd0;
            rx_word_d = 64'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    if (rx_done_d) begin
      ack_d     = 1'b1;
      ack_cnt_d = 16'd0;
    end else if (ack_q) begin
      if (ack_cnt_q == BIT_LAST) begin
        ack_d     = 1'b0;
        ack_cnt_d = 16'd0;
      end else begin
        ack_cnt_d = ack_cnt_q + 16'd1;
      end
    end else begin
      ack_d = 1'b0;
    end
  end

  // Receiver state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_byte_q  <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_word_q  <= 64'd0;
      rx_data_q  <= 64'd0;
      rx_done_q  <= 1'b0;
      ack_q      <= 1'b0;
      ack_cnt_q  <= 16'd0;
`ifdef TRANSCEIVER64_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_byte_q  <= rx_byte_d;
      rx_shift_q <= rx_shift_d;
      rx_word_q  <= rx_word_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      ack_q      <= ack_d;
      ack_cnt_q  <= ack_cnt_d;
`ifdef TRANSCEIVER64_PARITY_EN
      rx_par_err_q <= rx_par_err_d;
`endif
    end
  end

  assign UART_TX     = tx_line_q;
  assign tx_done     = tx_done_q;
  assign RECEIVED_TX = ack_q;
  assign rx_data     = rx_data_q;
  assign rx_done     = rx_done_q;

endmodule

// File: tb/tb_transceiver64.sv
// Directed bench for transceiver64: loopback transfer, ignored writes, missing ack, framing error, mid-word reset.
module tb_transceiver64;

  localparam int CPB = 16;
`ifdef TRANSCEIVER64_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int FRAME   = (10 + NPAR) * CPB;
  localparam int LAT_MIN = 8 * FRAME - 40;
  localparam int LAT_MAX = 8 * FRAME + 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tx_wr = 1'b0;
  logic [63:0] tx_data = 64'd0;
  logic        UART_TX, UART_RX, RECEIVED_TX, RECEIVED_RX;
  logic [63:0] rx_data;
  logic        rx_done, tx_done;

  logic rx_sel = 1'b0, tb_rx = 1'b1, ack_sel = 1'b0, tb_ack = 1'b0;
  assign UART_RX     = rx_sel  ? tb_rx  : UART_TX;
  assign RECEIVED_RX = ack_sel ? tb_ack : RECEIVED_TX;

  int checks = 0, errors = 0;
  int cyc = 0;
  int rx_done_cnt = 0, tx_done_cnt = 0, ack_hi_cnt = 0;
  int last_rx_cyc = 0, last_tx_cyc = 0;
  logic [7:0] txq[$];

  transceiver64 #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data),
    .UART_TX(UART_TX), .UART_RX(UART_RX), .RECEIVED_TX(RECEIVED_TX),
    .RECEIVED_RX(RECEIVED_RX), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_done === 1'b1) begin rx_done_cnt = rx_done_cnt + 1; last_rx_cyc = cyc; end
    if (tx_done === 1'b1) begin tx_done_cnt = tx_done_cnt + 1; last_tx_cyc = cyc; end
    if (RECEIVED_TX === 1'b1) ack_hi_cnt = ack_hi_cnt + 1;
  end

  // Line monitor: decodes the data byte of each frame on UART_TX.
  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (prev && !UART_TX) begin
        repeat (CPB / 2 - 1) @(negedge clock);
        if (!UART_TX) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            b[i] = UART_TX;
          end
          txq.push_back(b);
          repeat (CPB * (1 + NPAR)) @(negedge clock);
        end
      end
      prev = UART_TX;
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input int hold);
    tx_data = d;
    tx_wr   = 1'b1;
    tick(hold);
    tx_wr   = 1'b0;
  endtask

  task automatic wait_rx(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (rx_done_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tx(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (tx_done_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ser_byte(input logic [7:0] b, input logic stop);
    tb_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin tb_rx = b[i]; tick(CPB); end
`ifdef TRANSCEIVER64_PARITY_EN
    tb_rx = ^b; tick(CPB);
`endif
    tb_rx = stop; tick(CPB);
    tb_rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(10);
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", UART_TX); end
    checks++; if (RECEIVED_TX !== 1'b0) begin errors++; $display("FAIL reset_received_tx: got %b expected 0", RECEIVED_TX); end
    checks++; if (rx_data !== 64'd0) begin errors++; $display("FAIL reset_rx_data: got %h expected 0", rx_data); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
    reset = 1'b1;
    tick(5);
  endtask

  task automatic test_loopback();
    logic [63:0] w;
    int rb, tb_, ab, t0, lat;
    bit ok;
    w = 64'haabbccdd11223344;
    rb = rx_done_cnt; tb_ = tx_done_cnt; ab = ack_hi_cnt;
    txq.delete();
    t0 = cyc;
    send_word(w, 2);
    wait_rx(rb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_rx_timeout: got no rx_done expected one"); end
    checks++; if (rx_data !== w) begin errors++; $display("FAIL loop_rx_data: got %h expected %h", rx_data, w); end
    lat = last_rx_cyc - t0;
    checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL loop_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    wait_tx(tb_, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_tx_timeout: got no tx_done expected one"); end
    tick(60);
    checks++; if (rx_done_cnt - rb != 1) begin errors++; $display("FAIL loop_rx_pulses: got %0d expected 1", rx_done_cnt - rb); end
    checks++; if (tx_done_cnt - tb_ != 1) begin errors++; $display("FAIL loop_tx_pulses: got %0d expected 1", tx_done_cnt - tb_); end
    checks++; if (ack_hi_cnt - ab != CPB) begin errors++; $display("FAIL loop_ack_width: got %0d expected %0d", ack_hi_cnt - ab, CPB); end
    checks++; if (last_tx_cyc <= last_rx_cyc) begin errors++; $display("FAIL loop_ack_order: got tx_done at %0d expected after %0d", last_tx_cyc, last_rx_cyc); end
    checks++; if (txq.size() != 8) begin errors++; $display("FAIL loop_frames: got %0d expected 8", txq.size()); end
    if (txq.size() == 8) begin
      checks++; if (txq[0] !== 8'h44) begin errors++; $display("FAIL loop_first_byte: got %h expected 44", txq[0]); end
      checks++; if (txq[7] !== 8'haa) begin errors++; $display("FAIL loop_last_byte: got %h expected aa", txq[7]); end
    end
  endtask

  task automatic test_ignore_wr();
    logic [63:0] w;
    logic [7:0] eb;
    int rb, tb_, bad;
    bit ok;
    w = 64'haabbccdd11223344;
    rb = rx_done_cnt; tb_ = tx_done_cnt;
    txq.delete();
    send_word(w, 1);
    tick(400);
    send_word(64'd0, 1);
    wait_rx(rb, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_rx_timeout: got no rx_done expected one"); end
    checks++; if (rx_data !== w) begin errors++; $display("FAIL ign_rx_data: got %h expected %h", rx_data, w); end
    wait_tx(tb_, 200, ok);
    tick(200);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      eb = w[8*i +: 8];
      if (i >= txq.size() || txq[i] !== eb) bad++;
    end
    checks++; if (bad != 0 || txq.size() != 8) begin errors++; $display("FAIL ign_frames: got %0d frames with %0d wrong bytes expected 8 frames of %h", txq.size(), bad, w); end
    checks++; if (rx_done_cnt - rb != 1) begin errors++; $display("FAIL ign_rx_pulses: got %0d expected 1", rx_done_cnt - rb); end
  endtask

  task automatic test_no_ack();
    logic [63:0] w;
    int rb, tb_, ab;
    bit ok;
    w = 64'hfedcba9876543210;
    ack_sel = 1'b1; tb_ack = 1'b0;
    rb = rx_done_cnt; tb_ = tx_done_cnt; ab = ack_hi_cnt;
    txq.delete();
    send_word(w, 1);
    wait_rx(rb, 2000, ok);
    checks++; if (rx_data !== w) begin errors++; $display("FAIL noack_rx_data: got %h expected %h", rx_data, w); end
    tick(300);
    checks++; if (tx_done_cnt != tb_) begin errors++; $display("FAIL noack_tx_done: got %0d pulses expected 0", tx_done_cnt - tb_); end
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL noack_line: got %b expected 1", UART_TX); end
    checks++; if (ack_hi_cnt - ab != CPB) begin errors++; $display("FAIL noack_ack_width: got %0d expected %0d", ack_hi_cnt - ab, CPB); end
    send_word(64'h0, 1);
    tick(200);
    checks++; if (txq.size() != 8 || UART_TX !== 1'b1) begin errors++; $display("FAIL noack_wr_ignored: got %0d frames line %b expected 8 frames line 1", txq.size(), UART_TX); end
    checks++; if (tx_done_cnt != tb_) begin errors++; $display("FAIL noack_still_waiting: got %0d pulses expected 0", tx_done_cnt - tb_); end
    tb_ack = 1'b1;
    tick(6);
    tb_ack = 1'b0;
    ack_sel = 1'b0;
    tick(10);
    checks++; if (tx_done_cnt - tb_ != 1) begin errors++; $display("FAIL noack_release: got %0d pulses expected 1", tx_done_cnt - tb_); end
  endtask

  task automatic test_framing();
    logic [63:0] w, prev, good;
    int rb, ab;
    bit ok;
    w = 64'haabbccdd11223344;
    good = 64'h0123456789abcdef;
    prev = 64'hfedcba9876543210;
    rb = rx_done_cnt; ab = ack_hi_cnt;
    rx_sel = 1'b1; tb_rx = 1'b1;
    tick(5);
    for (int i = 0; i < 4; i++) ser_byte(w[8*i +: 8], (i == 3) ? 1'b0 : 1'b1);
    tick(100);
    checks++; if (rx_done_cnt != rb) begin errors++; $display("FAIL frm_rx_done: got %0d pulses expected 0", rx_done_cnt - rb); end
    checks++; if (ack_hi_cnt != ab) begin errors++; $display("FAIL frm_ack: got %0d high cycles expected 0", ack_hi_cnt - ab); end
    checks++; if (rx_data !== prev) begin errors++; $display("FAIL frm_rx_hold: got %h expected %h", rx_data, prev); end
    rx_sel = 1'b0;
    tick(5);
    send_word(good, 1);
    wait_rx(rb, 2000, ok);
    checks++; if (!ok || rx_data !== good) begin errors++; $display("FAIL frm_recover: got %h expected %h", rx_data, good); end
    wait_tx(0, 0, ok);
    tick(150);
    checks++; if (rx_done_cnt - rb != 1) begin errors++; $display("FAIL frm_rx_pulses: got %0d expected 1", rx_done_cnt - rb); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w, w2;
    int rb, tb_;
    bit ok;
    w = 64'haabbccdd11223344;
    w2 = 64'h0f1e2d3c4b5a6978;
    rb = rx_done_cnt; tb_ = tx_done_cnt;
    send_word(w, 1);
    tick(5 * FRAME + FRAME / 2);
    reset = 1'b0;
    tick(1);
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL rstmid_line: got %b expected 1", UART_TX); end
    tick(2);
    checks++; if (rx_data !== 64'd0) begin errors++; $display("FAIL rstmid_rx_data: got %h expected 0", rx_data); end
    reset = 1'b1;
    tick(300);
    checks++; if (rx_done_cnt != rb || tx_done_cnt != tb_) begin errors++; $display("FAIL rstmid_no_done: got rx %0d tx %0d pulses expected 0 0", rx_done_cnt - rb, tx_done_cnt - tb_); end
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL rstmid_idle_line: got %b expected 1", UART_TX); end
    txq.delete();
    send_word(w2, 1);
    wait_rx(rb, 2000, ok);
    checks++; if (!ok || rx_data !== w2) begin errors++; $display("FAIL rstmid_next_word: got %h expected %h", rx_data, w2); end
    wait_tx(tb_, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_tx_done: got no tx_done expected one"); end
    checks++; if (txq.size() != 8 || txq[0] !== 8'h78) begin errors++; $display("FAIL rstmid_first_byte: got %0d frames first %h expected 8 frames first 78", txq.size(), (txq.size() > 0) ? txq[0] : 8'h00); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_ignore_wr();
    test_no_ack();
    test_framing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
